prog_loader: RTL and testbench

- Writer side of the instruction-memory interface: receives a byte stream (e.g. from a UART or debug link), assembles WORD-bit instruction words, and writes them into the DP_mem32x64k port.
- Holds the core (ifetch and downstream) in reset while loading and releases it once the image is complete.
- Sits beside ifetch in top and owns the memory A/W/D inputs during load. The team's top-level mux selects loader vs. ifetch address using core_rst_o.

---
 rtl/prog_loader_pkg.sv | 26 ++
 rtl/prog_loader_if.sv | 15 +
 rtl/prog_loader_word_packer.sv | 45 ++++
 rtl/prog_loader.sv | 121 ++++++++++++
 tb/tb_prog_loader.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared widths and state encodings for the program loader
package prog_loader_pkg;

  // Memory word-address width and instruction word width
  localparam int ADDR  = 16;
  localparam int WORD  = 32;
  localparam int BYTES = WORD / 8;

  // Loader state encodings
  localparam logic [2:0] LD_IDLE = 3'd0;
  localparam logic [2:0] LD_LEN0 = 3'd1;
  localparam logic [2:0] LD_LEN1 = 3'd2;
  localparam logic [2:0] LD_DATA = 3'd3;
  localparam logic [2:0] LD_CSUM = 3'd4;
  localparam logic [2:0] LD_DONE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = LD_IDLE,
    S_LEN0 = LD_LEN0,
    S_LEN1 = LD_LEN1,
    S_DATA = LD_DATA,
    S_CSUM = LD_CSUM,
    S_DONE = LD_DONE
  } ld_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in and instruction-memory write port out
interface prog_loader_if;

  logic [7:0]                         byte_i;
  logic                               bv_i;
  logic                               brdy_o;
  logic [prog_loader_pkg::ADDR-1:0]   mem_a_o;
  logic                               mem_w_o;
  logic [prog_loader_pkg::WORD-1:0]   mem_d_o;

  // master: byte source and memory sink; slave: the loader itself
  modport master (output byte_i, bv_i, input brdy_o, mem_a_o, mem_w_o, mem_d_o);
  modport slave  (input byte_i, bv_i, output brdy_o, mem_a_o, mem_w_o, mem_d_o);

endinterface

// File: rtl/prog_loader_word_packer.sv
// rtl/prog_loader_word_packer.sv - assembles little-endian bytes into instruction words
module word_packer
  import prog_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [7:0]      data_in,
  output logic [WORD-1:0] word,
  output logic            last,
  output logic            done
);

  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IW-1:0] idx;

  // The byte being accepted now completes the current word
  assign last = en && (idx == IW'(BYTES - 1));

  // Byte lane fill; done pulses for one cycle while the full word is on word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      word <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        idx  <= '0;
        word <= '0;
      end else if (en) begin
        word[8*idx +: 8] <= data_in;
        if (last) begin
          idx  <= '0;
          done <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream image loader for instruction memory; LOADER_CSUM_EN adds an XOR trailer check
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [ADDR-1:0] BASE = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  prog_loader_if.slave    bus,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            core_rst_o
);

`ifdef LOADER_CSUM_EN
  localparam ld_state_t S_TAIL = S_CSUM;
`else
  localparam ld_state_t S_TAIL = S_DONE;
`endif

  ld_state_t        state, next;
  logic [7:0]       len_lo;
  logic [15:0]      left;
  logic [ADDR-1:0]  addr;
  logic             take;
  logic             start_go;
  logic [WORD-1:0]  word;
  logic             word_last;
  logic             word_done;

  assign take     = bus.bv_i && bus.brdy_o;
  assign start_go = start_i && (state == S_IDLE || state == S_DONE);

  word_packer u_pack (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_go),
    .en      (take && state == S_DATA),
    .data_in (bus.byte_i),
    .word    (word),
    .last    (word_last),
    .done    (word_done)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  // Next-state: header, payload, optional trailer, then park in DONE
  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_DONE: if (start_i) next = S_LEN0;
      S_LEN0:         if (take) next = S_LEN1;
      S_LEN1:         if (take) next = ({bus.byte_i, len_lo} == 16'd0) ? S_TAIL : S_DATA;
      S_DATA:         if (take && word_last && left == 16'd1) next = S_TAIL;
`ifdef LOADER_CSUM_EN
      S_CSUM:         if (take) next = S_DONE;
`endif
      default:        next = S_IDLE;
    endcase
  end

  // Word count and write address; address advances after each write pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo <= '0;
      left   <= '0;
      addr   <= BASE;
    end else if (start_go) begin
      left   <= '0;
      addr   <= BASE;
    end else begin
      if (state == S_LEN0 && take) len_lo <= bus.byte_i;
      if (state == S_LEN1 && take) left <= {bus.byte_i, len_lo};
      if (state == S_DATA && take && word_last) left <= left - 16'd1;
      if (word_done) addr <= addr + ADDR'(1);
    end
  end

`ifdef LOADER_CSUM_EN
  logic [7:0] csum;
  logic       err;

  // Running XOR of payload bytes, compared against the trailer byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (start_go) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (state == S_DATA && take) begin
      csum <= csum ^ bus.byte_i;
    end else if (state == S_CSUM && take) begin
      err  <= (bus.byte_i != csum);
    end
  end

  assign err_o = err;
`else
  assign err_o = 1'b0;
`endif

  assign bus.brdy_o  = (state == S_LEN0) || (state == S_LEN1) ||
                       (state == S_DATA) || (state == S_CSUM);
  assign bus.mem_w_o = word_done;
  assign bus.mem_d_o = word;
  assign bus.mem_a_o = addr;

  // The last write may still be in flight on the first DONE cycle; hold
  // done and the core reset until it has gone out
  assign busy_o     = !(state == S_IDLE || state == S_DONE);
  assign done_o     = (state == S_DONE) && !word_done;
  assign core_rst_o = !(done_o && !err_o);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
`define CK(tag, o, e) check(tag, 64'(o), 64'(e))

module tb_prog_loader;
  import prog_loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [7:0] sb = 8'h00;
  logic sv = 1'b0;
  logic busy0, done0, err0, crst0;
  logic busy1, done1, err1, crst1;

  int n_cmp = 0;
  int n_err = 0;

  logic [ADDR-1:0] qa0[$], qa1[$];
  logic [WORD-1:0] qd0[$], qd1[$];
  logic [7:0]      img[$];
  int              g;

  prog_loader_if bus0();
  prog_loader_if bus1();

  assign bus0.byte_i = sb;
  assign bus0.bv_i   = sv;
  assign bus1.byte_i = sb;
  assign bus1.bv_i   = sv;

  prog_loader #(.BASE(16'h0000)) dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .bus(bus0.slave),
    .busy_o(busy0), .done_o(done0), .err_o(err0), .core_rst_o(crst0)
  );

  prog_loader #(.BASE(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .bus(bus1.slave),
    .busy_o(busy1), .done_o(done1), .err_o(err1), .core_rst_o(crst1)
  );

  always #5 clk = ~clk;

  // Write log from both memory ports
  always @(negedge clk) begin
    if (bus0.mem_w_o) begin qa0.push_back(bus0.mem_a_o); qd0.push_back(bus0.mem_d_o); end
    if (bus1.mem_w_o) begin qa1.push_back(bus1.mem_a_o); qd1.push_back(bus1.mem_d_o); end
  end

  // Continuous invariants on instance 0
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (bus0.brdy_o !== busy0) begin
        n_err++;
        $error("FAIL mon_brdy_busy observed=%0b expected=%0b", bus0.brdy_o, busy0);
      end
      n_cmp++;
      if (crst0 !== !(done0 && !err0)) begin
        n_err++;
        $error("FAIL mon_crst observed=%0b expected=%0b", crst0, !(done0 && !err0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    sb = b; sv = 1'b1;
    tick();
  endtask

  task automatic pulse(input bit which);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic clear_log();
    qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
  endtask

  task automatic check_idle0(input string tag);
    `CK({tag, "_brdy"}, bus0.brdy_o, 0);
    `CK({tag, "_w"},    bus0.mem_w_o, 0);
    `CK({tag, "_a"},    bus0.mem_a_o, 16'h0000);
    `CK({tag, "_d"},    bus0.mem_d_o, 32'h0);
    `CK({tag, "_busy"}, busy0, 0);
    `CK({tag, "_done"}, done0, 0);
    `CK({tag, "_err"},  err0, 0);
    `CK({tag, "_crst"}, crst0, 1);
  endtask

  initial begin
    img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CSUM_EN
    img.push_back(8'h2A);
`endif

    repeat (3) tick();
    check_idle0("rst");
    `CK("rst_a1", bus1.mem_a_o, 16'hFFFF);
    rst = 1'b0;
    tick();

    pulse(0);
    `CK("ld_busy", busy0, 1);
    `CK("ld_brdy", bus0.brdy_o, 1);
    `CK("ld_crst", crst0, 1);
    send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34);
    `CK("w0_pre", bus0.mem_w_o, 0);
    send(8'h12);
    `CK("w0_en", bus0.mem_w_o, 1);
    `CK("w0_a",  bus0.mem_a_o, 16'h0000);
    `CK("w0_d",  bus0.mem_d_o, 32'h12345678);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    `CK("w1_en",   bus0.mem_w_o, 1);
    `CK("w1_a",    bus0.mem_a_o, 16'h0001);
    `CK("w1_d",    bus0.mem_d_o, 32'hDEADBEEF);
    `CK("w1_done", done0, 0);
    `CK("w1_crst", crst0, 1);
`ifdef LOADER_CSUM_EN
    send(8'h2A);
    sv = 1'b0;
`else
    sv = 1'b0;
    tick();
`endif
    `CK("d1_done", done0, 1);
    `CK("d1_crst", crst0, 0);
    `CK("d1_w",    bus0.mem_w_o, 0);
    `CK("d1_err",  err0, 0);
    `CK("d1_busy", busy0, 0);
    `CK("d1_brdy", bus0.brdy_o, 0);
    `CK("d1_other_busy", busy1, 0);
    `CK("d1_other_writes", qa1.size(), 0);

    clear_log();
    pulse(0);
    `CK("gap_done_clr", done0, 0);
    `CK("gap_crst", crst0, 1);
    for (int i = 0; i < img.size(); i++) begin
      g = $urandom_range(0, 3);
      sv = 1'b0;
      repeat (g) begin
        tick();
        `CK("gap_brdy_idle", bus0.brdy_o, 1);
      end
      sb = img[i]; sv = 1'b1;
      `CK("gap_brdy", bus0.brdy_o, 1);
      tick();
    end
    sv = 1'b0;
    repeat (2) tick();
    `CK("gap_n",  qa0.size(), 2);
    `CK("gap_a0", qa0[0], 16'h0000);
    `CK("gap_d0", qd0[0], 32'h12345678);
    `CK("gap_a1", qa0[1], 16'h0001);
    `CK("gap_d1", qd0[1], 32'hDEADBEEF);
    `CK("gap_done", done0, 1);

    clear_log();
    pulse(0);
    send(8'h00); send(8'h00);
`ifdef LOADER_CSUM_EN
    send(8'h00);
`endif
    sv = 1'b0;
    `CK("n0_done", done0, 1);
    `CK("n0_crst", crst0, 0);
    repeat (2) tick();
    `CK("n0_writes", qa0.size(), 0);

    clear_log();
    pulse(1);
    foreach (img[i]) send(img[i]);
    sv = 1'b0;
    repeat (2) tick();
    `CK("wrap_n",  qa1.size(), 2);
    `CK("wrap_a0", qa1[0], 16'hFFFF);
    `CK("wrap_d0", qd1[0], 32'h12345678);
    `CK("wrap_a1", qa1[1], 16'h0000);
    `CK("wrap_d1", qd1[1], 32'hDEADBEEF);
    `CK("wrap_done", done1, 1);
    `CK("wrap_other", qa0.size(), 0);

    clear_log();
    pulse(0);
    send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12); send(8'hEF); send(8'hBE);
    sv = 1'b0;
    rst = 1'b1;
    #1;
    check_idle0("mid");
    repeat (3) tick();
    rst = 1'b0;
    tick();
    `CK("mid_writes", qa0.size(), 1);

    clear_log();
    pulse(0);
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08);
`ifdef LOADER_CSUM_EN
    send(8'h0F);
`endif
    sv = 1'b0;
    repeat (2) tick();
    `CK("re_n",    qa0.size(), 1);
    `CK("re_a",    qa0[0], 16'h0000);
    `CK("re_d",    qd0[0], 32'h08040201);
    `CK("re_done", done0, 1);
    `CK("re_err",  err0, 0);
    `CK("re_crst", crst0, 0);

`ifdef LOADER_CSUM_EN
    pulse(0);
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08);
    send(8'h0E);
    sv = 1'b0;
    tick();
    `CK("bad_err",  err0, 1);
    `CK("bad_done", done0, 1);
    `CK("bad_crst", crst0, 1);
    pulse(0);
    `CK("bad_err_clr", err0, 0);
    `CK("bad_crst2",   crst0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
